// File: rtl/snn_cfg_sequencer.sv
// rtl/snn_cfg_sequencer.sv - configuration loader and timestep sequencer for the three-layer spiking network
//
// Purpose
//   Shifts a byte-wide, MSB-first configuration frame into a shadow register,
//   commits it atomically to the network's weight/parameter buses, and
//   generates the network's one-cycle timestep strobe in free-running or
//   single-step mode.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_start       pulse: begin or restart a configuration frame
//   cfg_valid       cfg_data holds a byte
//   cfg_data        configuration byte
//   cfg_ready       byte accepted when cfg_valid & cfg_ready
//   run             level: free-running timestep mode
//   step            pulse: single timestep when run=0
//   input_weights   active weights (WEIGHT_BITS)
//   neuron_params   active neuron params (PARAM_BITS)
//   net_enable      one-cycle timestep strobe
//   cfg_loaded      at least one frame committed since reset
//   cfg_err         one-cycle pulse: frame aborted or rejected
//
// Configuration macro
//   SNN_CFG_CHECKSUM_EN  frame carries a trailing XOR byte that must match
//                        before the commit happens.

module snn_cfg_sequencer #(
  parameter int WEIGHT_BITS = 216,
  parameter int PARAM_BITS  = 96,
  parameter int TICK_DIV    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic [7:0]             cfg_data,
  output logic                   cfg_ready,
  input  logic                   run,
  input  logic                   step,
  output logic [WEIGHT_BITS-1:0] input_weights,
  output logic [PARAM_BITS-1:0]  neuron_params,
  output logic                   net_enable,
  output logic                   cfg_loaded,
  output logic                   cfg_err
);

  localparam int N      = WEIGHT_BITS + PARAM_BITS;
  localparam int NBYTES = N / 8;
`ifdef SNN_CFG_CHECKSUM_EN
  localparam int FRAME_LEN = NBYTES + 1;
`else
  localparam int FRAME_LEN = NBYTES;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [N-1:0]    shadow, shadow_nxt;
  logic            err_nxt;
  logic [TW-1:0]   tick_cnt;
  logic            step_pend;
  logic            commit;
  logic            tick_fire;
  logic            step_fire;
`ifdef SNN_CFG_CHECKSUM_EN
  logic [7:0]      csum, csum_nxt;
`endif

  // ---------------------------------------------------------------- loader FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      shadow   <= '0;
      cfg_err  <= 1'b0;
`ifdef SNN_CFG_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      shadow   <= shadow_nxt;
      cfg_err  <= err_nxt;
`ifdef SNN_CFG_CHECKSUM_EN
      csum     <= csum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shadow_nxt   = shadow;
    err_nxt      = 1'b0;
    cfg_ready    = 1'b0;
`ifdef SNN_CFG_CHECKSUM_EN
    csum_nxt     = csum;
`endif
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt    = LOAD;
          byte_cnt_nxt = '0;
`ifdef SNN_CFG_CHECKSUM_EN
          csum_nxt     = '0;
`endif
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        // A restart wins over any byte presented in the same cycle; that
        // byte is dropped and the frame begins again from byte 0.
        if (cfg_start) begin
          err_nxt      = 1'b1;
          byte_cnt_nxt = '0;
`ifdef SNN_CFG_CHECKSUM_EN
          csum_nxt     = '0;
`endif
        end else if (cfg_valid) begin
`ifdef SNN_CFG_CHECKSUM_EN
          if (byte_cnt == CW'(NBYTES)) begin
            // Trailing check byte: never enters the shadow.
            if (cfg_data == csum) begin
              state_nxt = COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            shadow_nxt   = {shadow[N-9:0], cfg_data};
            csum_nxt     = csum ^ cfg_data;
            byte_cnt_nxt = byte_cnt + CW'(1);
          end
`else
          shadow_nxt   = {shadow[N-9:0], cfg_data};
          byte_cnt_nxt = byte_cnt + CW'(1);
          if (byte_cnt == CW'(NBYTES - 1)) begin
            state_nxt = COMMIT;
          end
`endif
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Active buses only move in the COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_weights <= '0;
      neuron_params <= '0;
      cfg_loaded    <= 1'b0;
    end else if (state == COMMIT) begin
      input_weights <= shadow[N-1:PARAM_BITS];
      neuron_params <= shadow[PARAM_BITS-1:0];
      cfg_loaded    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- sequencer
  // In the COMMIT cycle the tick counter freezes and step requests are held
  // over, so a strobe always lands one cycle after the buses change.
  assign commit    = (state == COMMIT);
  assign tick_fire = run && !commit && (tick_cnt == TW'(TICK_DIV - 1));
  assign step_fire = !run && !commit && (step || step_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      step_pend  <= 1'b0;
      net_enable <= 1'b0;
    end else begin
      if (!run) begin
        tick_cnt <= '0;
      end else if (!commit) begin
        if (tick_cnt == TW'(TICK_DIV - 1)) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
      step_pend  <= !run && commit && (step || step_pend);
      net_enable <= cfg_loaded && (tick_fire || step_fire);
    end
  end

endmodule
